// File: rtl/mfcc_frame_sequencer.sv
`default_nettype none
// mfcc_frame_sequencer: feeds framed audio to an MFCC accelerator and buffers the
// returned coefficients in a first-word-fall-through FIFO.  Rev 1.0
module mfcc_frame_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  cfg_frame_size,
  input  logic [7:0]  cfg_frame_overlap,
  input  logic [7:0]  cfg_num_coeffs,
  input  logic [7:0]  cfg_num_frames,
  input  logic [15:0] audio_in,
  input  logic        audio_in_valid,
  output logic        audio_in_ready,
  output logic [15:0] acc_audio,
  output logic        acc_audio_valid,
  input  logic [31:0] acc_mfcc,
  input  logic        acc_mfcc_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  frame_idx,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic        err_overflow,
  output logic        err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [1:0]    state;
  logic [7:0]    size_q, ovl_q, ncoef_q, nframes_q;
  logic [7:0]    sample_cnt, coef_cnt;
  logic [15:0]   tmo_cnt;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic       cfg_ok, audio_xfer, coef_in, coef_last, fifo_empty, fifo_full;
  logic       pop, push_ok, stopping;
  logic [7:0] need, frame_next;

  assign cfg_ok = (cfg_frame_size != 8'd0) && (cfg_num_coeffs != 8'd0) &&
                  (cfg_num_frames != 8'd0) && (cfg_frame_overlap < cfg_frame_size);
  assign stopping   = stop && (state != S_IDLE);
  // Ready is withdrawn during a stop so the source never sees a sample vanish.
  assign audio_in_ready = (state == S_FEED) && !stop;
  assign audio_xfer = audio_in_valid && audio_in_ready;
  assign need       = (frame_idx == 8'd0) ? size_q : (size_q - ovl_q);
  assign coef_in    = acc_mfcc_valid && !stop && ((state == S_FEED) || (state == S_WAIT));
  assign coef_last  = (coef_cnt + 8'd1) == ncoef_q;
  assign frame_next = frame_idx + 8'd1;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = !fifo_empty && out_ready;
  assign push_ok    = coef_in && (!fifo_full || pop);

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 32'd0 : mem[rd_ptr][31:0];
  assign out_last  = fifo_empty ? 1'b0 : mem[rd_ptr][32];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {coef_last, acc_mfcc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      size_q          <= 8'd0;
      ovl_q           <= 8'd0;
      ncoef_q         <= 8'd0;
      nframes_q       <= 8'd0;
      sample_cnt      <= 8'd0;
      coef_cnt        <= 8'd0;
      tmo_cnt         <= 16'd0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      frame_idx       <= 8'd0;
      acc_audio       <= 16'd0;
      acc_audio_valid <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
      err_overflow    <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      done            <= 1'b0;
      acc_audio_valid <= audio_xfer;
      if (audio_xfer) begin
        acc_audio <= audio_in;
      end

      if (stopping) begin
        state      <= S_IDLE;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        sample_cnt <= 8'd0;
        coef_cnt   <= 8'd0;
        tmo_cnt    <= 16'd0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (push_ok && !pop) begin
          count <= count + CNT_ONE;
        end else if (!push_ok && pop) begin
          count <= count - CNT_ONE;
        end
        if (coef_in && fifo_full && !pop) begin
          err_overflow <= 1'b1;
        end

        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                size_q       <= cfg_frame_size;
                ovl_q        <= cfg_frame_overlap;
                ncoef_q      <= cfg_num_coeffs;
                nframes_q    <= cfg_num_frames;
                frame_idx    <= 8'd0;
                sample_cnt   <= 8'd0;
                coef_cnt     <= 8'd0;
                tmo_cnt      <= 16'd0;
                cfg_err      <= 1'b0;
                err_overflow <= 1'b0;
                err_timeout  <= 1'b0;
                state        <= S_FEED;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          S_FEED, S_WAIT: begin
            if (audio_xfer) begin
              if ((sample_cnt + 8'd1) == need) begin
                sample_cnt <= 8'd0;
                state      <= S_WAIT;
              end else begin
                sample_cnt <= sample_cnt + 8'd1;
              end
            end
            if (state == S_WAIT) begin
              tmo_cnt <= tmo_cnt + 16'd1;
              if ((tmo_cnt + 16'd1) == TIMEOUT_VAL) begin
                err_timeout <= 1'b1;
                state       <= S_DRAIN;
              end
            end
            // Frame completion outranks both the sample-count and timeout transitions.
            if (coef_in) begin
              if (coef_last) begin
                coef_cnt  <= 8'd0;
                tmo_cnt   <= 16'd0;
                frame_idx <= frame_next;
                state     <= (frame_next == nframes_q) ? S_DRAIN : S_FEED;
              end else begin
                coef_cnt <= coef_cnt + 8'd1;
              end
            end
          end
          S_DRAIN: begin
            if (fifo_empty) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mfcc_frame_sequencer.sv
`default_nettype none
// tb_mfcc_frame_sequencer: randomized scenarios checked against a queue-based
// model of framing, coefficient buffering and error behaviour.
module tb_mfcc_frame_sequencer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start_t = 1'b0, stop = 1'b0;
  logic [7:0] cfg_frame_size = 8'd0, cfg_frame_overlap = 8'd0;
  logic [7:0] cfg_num_coeffs = 8'd0, cfg_num_frames = 8'd0;
  logic [15:0] audio_in = 16'd0;
  logic audio_in_valid = 1'b0;
  logic [31:0] acc_mfcc = 32'd0;
  logic acc_mfcc_valid = 1'b0;
  logic out_ready = 1'b0;

  logic audio_in_ready, acc_audio_valid, out_last, out_valid, busy, done;
  logic cfg_err, err_overflow, err_timeout;
  logic [15:0] acc_audio;
  logic [31:0] out_data;
  logic [7:0] frame_idx;

  logic t_audio_in_ready, t_acc_audio_valid, t_out_last, t_out_valid, t_busy, t_done;
  logic t_cfg_err, t_err_overflow, t_err_timeout;
  logic [15:0] t_acc_audio;
  logic [31:0] t_out_data;
  logic [7:0] t_frame_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mfcc_frame_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(4095)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_frame_size(cfg_frame_size), .cfg_frame_overlap(cfg_frame_overlap),
    .cfg_num_coeffs(cfg_num_coeffs), .cfg_num_frames(cfg_num_frames),
    .audio_in(audio_in), .audio_in_valid(audio_in_valid), .audio_in_ready(audio_in_ready),
    .acc_audio(acc_audio), .acc_audio_valid(acc_audio_valid),
    .acc_mfcc(acc_mfcc), .acc_mfcc_valid(acc_mfcc_valid),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .frame_idx(frame_idx), .busy(busy), .done(done), .cfg_err(cfg_err),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  mfcc_frame_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(10)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .stop(stop),
    .cfg_frame_size(cfg_frame_size), .cfg_frame_overlap(cfg_frame_overlap),
    .cfg_num_coeffs(cfg_num_coeffs), .cfg_num_frames(cfg_num_frames),
    .audio_in(audio_in), .audio_in_valid(audio_in_valid), .audio_in_ready(t_audio_in_ready),
    .acc_audio(t_acc_audio), .acc_audio_valid(t_acc_audio_valid),
    .acc_mfcc(acc_mfcc), .acc_mfcc_valid(acc_mfcc_valid),
    .out_data(t_out_data), .out_last(t_out_last), .out_valid(t_out_valid), .out_ready(out_ready),
    .frame_idx(t_frame_idx), .busy(t_busy), .done(t_done), .cfg_err(t_cfg_err),
    .err_overflow(t_err_overflow), .err_timeout(t_err_timeout)
  );

  task automatic set_cfg(input int size, input int ovl, input int nc, input int nf);
    cfg_frame_size    = 8'(size);
    cfg_frame_overlap = 8'(ovl);
    cfg_num_coeffs    = 8'(nc);
    cfg_num_frames    = 8'(nf);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({audio_in_ready, acc_audio, acc_audio_valid, out_data, out_last, out_valid,
         busy, done, cfg_err, err_overflow, err_timeout, frame_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b aud=%h av=%b od=%h ol=%b ov=%b busy=%b done=%b fi=%0d, want all 0",
               audio_in_ready, acc_audio, acc_audio_valid, out_data, out_last, out_valid, busy, done, frame_idx);
    end
    checks++;
    if ({t_busy, t_out_valid, t_err_timeout, t_audio_in_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_timeout_inst: got busy=%b ov=%b et=%b rdy=%b, want 0", t_busy, t_out_valid, t_err_timeout, t_audio_in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cfg_err();
    int bad_ovl [2] = '{8, 3};
    int bad_nc  [2] = '{3, 0};
    for (int i = 0; i < 2; i++) begin
      set_cfg(8, bad_ovl[i], bad_nc[i], 2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || audio_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_%0d: got cfg_err=%b busy=%b ready=%b, want 1 0 0", i, cfg_err, busy, audio_in_ready);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cfg_err !== 1'b1) begin
        errors++;
        $display("FAIL cfg_err_hold_%0d: got busy=%b cfg_err=%b, want 0 1", i, busy, cfg_err);
      end
    end
  endtask

  // Full run against the model: sample stream, per-frame sample counts, FIFO contents
  // and ordering, overflow dropping, and exactly one done pulse.
  task automatic run_stream(input string name, input int size, input int ovl, input int nc,
                            input int nf, input int delay, input bit always_valid,
                            input bit hold_ready);
    logic [15:0] sq[$];
    logic [32:0] eq[$];
    logic [32:0] w;
    int fr, fs, cd, left, sent, cyc, need, extra, n_out, n_samp, n_done, exp_out;
    bit ovf_exp;
    fr = 0; fs = 0; cd = -1; left = 0; sent = 0; cyc = 0; extra = -1;
    n_out = 0; n_samp = 0; n_done = 0; exp_out = 0; ovf_exp = 1'b0;
    set_cfg(size, ovl, nc, nf);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 4000 && !(n_done > 0 && extra == 0)) begin
      if (done) n_done++;
      if (acc_audio_valid) begin
        checks++;
        if (sq.size() == 0 || acc_audio !== sq[0]) begin
          errors++;
          $display("FAIL %s acc_audio: got %h, want %h", name, acc_audio, (sq.size() != 0) ? sq[0] : 16'hxxxx);
        end
        if (sq.size() != 0) void'(sq.pop_front());
        n_samp++;
        fs++;
        need = (fr == 0) ? size : size - ovl;
        if (fs == need) begin
          fs = 0;
          cd = delay;
        end
      end
      acc_mfcc_valid = 1'b0;
      if (cd > 0) cd--;
      else if (cd == 0) begin
        left = nc;
        cd = -1;
      end
      if (left > 0) begin
        acc_mfcc_valid = 1'b1;
        acc_mfcc = $urandom;
        w = {(left == 1), acc_mfcc};
        left--;
        if (left == 0) begin
          fr++;
          sent++;
        end
      end else begin
        w = '0;
      end
      audio_in_valid = always_valid ? 1'b1 : 1'($urandom_range(0, 1));
      audio_in = 16'($urandom);
      out_ready = hold_ready ? (sent == nf && left == 0) : 1'($urandom_range(0, 1));
      #1;
      if (audio_in_valid && audio_in_ready) sq.push_back(audio_in);
      checks++;
      if (out_valid !== (eq.size() != 0)) begin
        errors++;
        $display("FAIL %s out_valid: got %b, want %b", name, out_valid, eq.size() != 0);
      end
      if (eq.size() != 0) begin
        checks++;
        if ({out_last, out_data} !== eq[0]) begin
          errors++;
          $display("FAIL %s out_word: got last=%b data=%h, want last=%b data=%h", name, out_last, out_data, eq[0][32], eq[0][31:0]);
        end
        if (out_ready) begin
          void'(eq.pop_front());
          n_out++;
        end
      end
      if (acc_mfcc_valid) begin
        if (eq.size() < DEPTH) begin
          eq.push_back(w);
          exp_out++;
        end else begin
          ovf_exp = 1'b1;
        end
      end
      if (n_done > 0 && extra < 0) extra = 5;
      else if (extra > 0) extra--;
      cyc++;
      @(negedge clk);
    end
    acc_mfcc_valid = 1'b0;
    audio_in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d pulses in %0d cycles, want 1", name, n_done, cyc);
    end
    checks++;
    if (n_samp != size + (nf - 1) * (size - ovl)) begin
      errors++;
      $display("FAIL %s sample_count: got %0d, want %0d", name, n_samp, size + (nf - 1) * (size - ovl));
    end
    checks++;
    if (n_out != exp_out || eq.size() != 0) begin
      errors++;
      $display("FAIL %s output_count: got %0d, want %0d", name, n_out, exp_out);
    end
    checks++;
    if (frame_idx !== 8'(nf) || busy !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state: got frame_idx=%0d busy=%b cfg_err=%b, want %0d 0 0", name, frame_idx, busy, cfg_err, nf);
    end
    checks++;
    if (err_overflow !== ovf_exp || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s err_flags: got ovf=%b tmo=%b, want ovf=%b tmo=0", name, err_overflow, err_timeout, ovf_exp);
    end
  endtask

  task automatic test_basic();
    run_stream("basic", 8, 4, 3, 2, 5, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int s, o;
    for (int i = 0; i < 4; i++) begin
      s = $urandom_range(2, 12);
      o = $urandom_range(0, s - 1);
      run_stream("random", s, o, $urandom_range(1, 5), $urandom_range(1, 4),
                 $urandom_range(0, 6), 1'b0, 1'b0);
    end
  endtask

  task automatic test_overflow();
    run_stream("overflow", 4, 0, 20, 1, 2, 1'b1, 1'b1);
  endtask

  task automatic test_timeout();
    int k;
    set_cfg(4, 0, 3, 2);
    acc_mfcc_valid = 1'b0;
    audio_in_valid = 1'b1;
    out_ready = 1'b1;
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    k = 0;
    while (k < 50 && !(t_busy && !t_audio_in_ready)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 50) begin
      errors++;
      $display("FAIL timeout_enter_wait: got busy=%b ready=%b after 50 cycles, want WAIT_COEF", t_busy, t_audio_in_ready);
    end
    for (int w = 1; w <= 10; w++) begin
      if (t_err_timeout !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL timeout_early: got err_timeout=1 at wait cycle %0d, want 0 until cycle 11", w);
      end
      @(negedge clk);
    end
    checks++;
    if (t_err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: got err_timeout=%b at wait cycle 11, want 1", t_err_timeout);
    end
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (t_done) k++;
      @(negedge clk);
    end
    checks++;
    if (k != 1 || t_busy !== 1'b0 || t_err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_drain: got done pulses=%0d busy=%b err=%b, want 1 0 1", k, t_busy, t_err_timeout);
    end
    audio_in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_stop();
    int k, dn;
    set_cfg(8, 4, 3, 3);
    audio_in_valid = 1'b1;
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 50 && !(busy && !audio_in_ready)) begin
      audio_in = 16'($urandom);
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      acc_mfcc_valid = 1'b1;
      acc_mfcc = $urandom;
      @(negedge clk);
    end
    acc_mfcc_valid = 1'b0;
    k = 0;
    while (k < 50 && !(frame_idx == 8'd1 && audio_in_ready)) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || frame_idx !== 8'd1) begin
      errors++;
      $display("FAIL stop_setup: got out_valid=%b busy=%b frame_idx=%0d, want 1 1 1", out_valid, busy, frame_idx);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || audio_in_ready !== 1'b0 || acc_audio_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: got busy=%b out_valid=%b ready=%b av=%b done=%b, want all 0",
               busy, out_valid, audio_in_ready, acc_audio_valid, done);
    end
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL stop_no_done: got %0d cycles with done/busy, want 0", dn);
    end
    audio_in_valid = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int k;
    set_cfg(4, 0, 3, 1);
    audio_in_valid = 1'b1;
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 50 && !(busy && !audio_in_ready)) begin
      audio_in = 16'h8000 | 16'($urandom);
      @(negedge clk);
      k++;
    end
    audio_in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      acc_mfcc_valid = 1'b1;
      acc_mfcc = 32'h8000_0000 | $urandom;
      @(negedge clk);
    end
    acc_mfcc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || acc_audio === 16'd0) begin
      errors++;
      $display("FAIL rst_setup: got out_valid=%b busy=%b acc_audio=%h, want 1 1 nonzero", out_valid, busy, acc_audio);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({audio_in_ready, acc_audio, acc_audio_valid, out_data, out_last, out_valid,
         busy, done, cfg_err, err_overflow, err_timeout, frame_idx} !== '0) begin
      errors++;
      $display("FAIL rst_midrun: got aud=%h av=%b od=%h ol=%b ov=%b busy=%b fi=%0d, want all 0",
               acc_audio, acc_audio_valid, out_data, out_last, out_valid, busy, frame_idx);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_fifo_empty: got out_valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cfg_err();
    test_basic();
    test_random();
    test_overflow();
    test_timeout();
    test_stop();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
